// File: rtl/data_mem_access_ctrl_pkg.sv
// data_mem_access_ctrl_pkg: size, state and opcode decode constants shared by the access controller and control.
package data_mem_access_ctrl_pkg;
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;
    localparam logic [10:0] OP_LDUR   = 11'h7C2;
    localparam logic [10:0] OP_STUR   = 11'h7C0;
    localparam logic [10:0] OP_LDURSW = 11'h5C4;
    localparam logic [10:0] OP_STURW  = 11'h5C0;
    localparam logic [10:0] OP_LDURH  = 11'h3C2;
    localparam logic [10:0] OP_STURH  = 11'h3C0;
    localparam logic [10:0] OP_LDURB  = 11'h1C2;
    localparam logic [10:0] OP_STURB  = 11'h1C0;
    typedef struct packed {
        logic [1:0] size;
        logic       sgn;
    } mem_op_t;
    function automatic mem_op_t decode_op(input logic [10:0] op);
        mem_op_t r;
        r.size = (op == OP_LDUR || op == OP_STUR) ? SZ_DWORD :
                 (op == OP_LDURSW || op == OP_STURW) ? SZ_WORD :
                 (op == OP_LDURH || op == OP_STURH) ? SZ_HALF : SZ_BYTE;
        r.sgn  = (op == OP_LDURSW);
        return r;
    endfunction
    // offset bits that must be zero for a naturally aligned access of this size
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        return (size == SZ_BYTE) ? 3'b000 : (size == SZ_HALF) ? 3'b001 :
               (size == SZ_WORD) ? 3'b011 : 3'b111;
    endfunction
endpackage

// File: rtl/data_mem_access_ctrl_byte_lane_unit.sv
// byte_lane_unit: extracts/extends a load lane and merges store bytes into a doubleword.
module byte_lane_unit #(
    parameter int WORD = 64
) (
    input  logic [WORD-1:0] dword,
    input  logic [WORD-1:0] wdata,
    input  logic [2:0]      off,
    input  logic [1:0]      size,
    input  logic            sgn,
    output logic [WORD-1:0] rdata,
    output logic [WORD-1:0] merged
);
    logic [6:0]      bits;
    logic [5:0]      sh;
    logic [WORD-1:0] mask, lane;
    logic            msb;
    assign bits   = 7'd8 << size;
    assign sh     = {off, 3'b000};
    assign mask   = ~({WORD{1'b1}} << bits);
    assign lane   = (dword >> sh) & mask;
    assign msb    = |(lane & (mask ^ (mask >> 1)));
    assign rdata  = (sgn && msb) ? (lane | ~mask) : lane;
    assign merged = (dword & ~(mask << sh)) | ((wdata & mask) << sh);
endmodule

// File: rtl/data_mem_access_ctrl.sv
// data_mem_access_ctrl: sub-word load/store to doubleword memory cycles with read-modify-write stores.
// Define DATA_MEM_ACCESS_ALIGN_CHECK_EN to reject misaligned requests with resp_err instead of force-aligning them.
module data_mem_access_ctrl
    import data_mem_access_ctrl_pkg::*;
#(
    parameter int WORD       = 64,
    parameter int MEM_RD_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [WORD-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            resp_valid,
    output logic [WORD-1:0] resp_rdata,
    output logic            resp_err,
    output logic            busy,
    output logic [WORD-1:0] mem_addr,
    output logic            mem_read,
    output logic            mem_write,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata
);
    localparam logic [1:0] LAST = 2'(MEM_RD_LAT - 1);
    logic [1:0]      state_q, state_d, size_q, cnt_q;
    logic [WORD-1:0] addr_q, wdata_q, cap_q, lane_rdata, lane_merged;
    logic            sign_q, write_q, err_q, busy_q, accept, rd_done, mis;
    logic [2:0]      off;
`ifdef DATA_MEM_ACCESS_ALIGN_CHECK_EN
    assign mis      = |(req_addr[2:0] & align_mask(req_size));
    assign resp_err = resp_valid & err_q;
`else
    assign mis      = 1'b0;
    assign resp_err = 1'b0;
`endif
    assign accept  = (state_q == ST_IDLE) && req_valid;
    assign rd_done = (state_q == ST_READ) && (cnt_q == LAST);
    assign off     = addr_q[2:0] & ~align_mask(size_q);
    always_comb begin
        state_d = (state_q == ST_IDLE)  ? (!accept ? ST_IDLE : mis ? ST_RESP :
                                           (req_write && req_size == SZ_DWORD) ? ST_WRITE : ST_READ) :
                  (state_q == ST_READ)  ? (!rd_done ? ST_READ : write_q ? ST_WRITE : ST_RESP) :
                  (state_q == ST_WRITE) ? ST_RESP : ST_IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cap_q   <= '0;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == ST_READ && state_d == ST_READ) ? cnt_q + 2'd1 : 2'd0;
            busy_q  <= accept || (state_q != ST_IDLE);
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                sign_q  <= req_signed;
                write_q <= req_write;
                err_q   <= mis;
            end
            if (rd_done) cap_q <= mem_rdata;
        end
    end
    // a full-size merge mask makes the doubleword store path fall out of the same merge
    byte_lane_unit #(.WORD(WORD)) u_lane (
        .dword  (cap_q),
        .wdata  (wdata_q),
        .off    (off),
        .size   (size_q),
        .sgn    (sign_q),
        .rdata  (lane_rdata),
        .merged (lane_merged)
    );
    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = busy_q;
    assign mem_addr   = {addr_q[WORD-1:3], 3'b000};
    assign mem_read   = (state_q == ST_READ);
    assign mem_write  = (state_q == ST_WRITE);
    assign mem_wdata  = mem_write ? lane_merged : '0;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = (resp_valid && !write_q && !err_q) ? lane_rdata : '0;
endmodule
